// File: rtl/decoder_seq_if.sv
// Command and result bundle for decoder_seq.
// The master drives commands; the slave returns the decoded pattern.
interface decoder_seq_if #(
  parameter int IN_W = 3
);
  localparam int OUT_W = 2 ** IN_W;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_num;
  logic [1:0]       in_mode;
  logic [OUT_W-1:0] res;
  logic             res_valid;
  logic             busy;
  logic             scan_done;

  modport master (
    output in_valid, in_num, in_mode,
    input  in_ready, res, res_valid, busy, scan_done
  );

  modport slave (
    input  in_valid, in_num, in_mode,
    output in_ready, res, res_valid, busy, scan_done
  );
endinterface

// File: rtl/decoder_seq.sv
// Registered N-to-2^N decoder with one-hot, thermometer, clear
// and timed scan modes behind a valid/ready command handshake.
module decoder_seq #(
  parameter int IN_W  = 3,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  decoder_seq_if.slave bus
);
  localparam int OUT_W = 2 ** IN_W;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

  localparam logic [1:0] M_ONEHOT = 2'b00;
  localparam logic [1:0] M_THERM  = 2'b01;
  localparam logic [1:0] M_SCAN   = 2'b10;
  localparam logic [1:0] M_CLEAR  = 2'b11;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             scan_done_q, scan_done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  pos_q, pos_d;
  logic [IN_W-1:0]  num_q, num_d;

  logic             accept;
  logic [OUT_W:0]   therm;

  assign accept = bus.in_valid && (state_q == IDLE);

  // One extra bit so index OUT_W-1 yields all ones without overflow.
  assign therm = ((OUT_W + 1)'(2) << bus.in_num) - (OUT_W + 1)'(1);

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    scan_done_d = 1'b0;
    cnt_d       = cnt_q;
    pos_d       = pos_q;
    num_d       = num_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (bus.in_mode)
            M_ONEHOT: begin
              res_d       = OUT_W'(1) << bus.in_num;
              res_valid_d = 1'b1;
            end
            M_THERM: begin
              res_d       = therm[OUT_W-1:0];
              res_valid_d = 1'b1;
            end
            M_SCAN: begin
              state_d     = SCAN;
              res_d       = OUT_W'(1);
              res_valid_d = 1'b1;
              cnt_d       = RELOAD;
              pos_d       = '0;
              num_d       = bus.in_num;
            end
            M_CLEAR: begin
              res_d       = '0;
              res_valid_d = 1'b0;
            end
          endcase
        end
      end
      SCAN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (pos_q != num_q) begin
          pos_d = pos_q + 1'b1;
          res_d = res_q << 1;
          cnt_d = RELOAD;
        end else begin
          state_d     = IDLE;
          res_d       = '0;
          res_valid_d = 1'b0;
          scan_done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      scan_done_q <= 1'b0;
      cnt_q       <= '0;
      pos_q       <= '0;
      num_q       <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      scan_done_q <= scan_done_d;
      cnt_q       <= cnt_d;
      pos_q       <= pos_d;
      num_q       <= num_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == SCAN);
  assign bus.res       = res_q;
  assign bus.res_valid = res_valid_q;
  assign bus.scan_done = scan_done_q;
endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: three instances cover
// IN_W=3/DWELL=4, IN_W=3/DWELL=1 and IN_W=4/DWELL=4.
module tb_decoder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  decoder_seq_if #(.IN_W(3)) if_a ();
  decoder_seq_if #(.IN_W(3)) if_b ();
  decoder_seq_if #(.IN_W(4)) if_c ();

  decoder_seq #(.IN_W(3), .DWELL(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  decoder_seq #(.IN_W(3), .DWELL(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  decoder_seq #(.IN_W(4), .DWELL(4)) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (if_c.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_a.in_valid = 1'b0; if_a.in_mode = 2'b00; if_a.in_num = '0;
    if_b.in_valid = 1'b0; if_b.in_mode = 2'b00; if_b.in_num = '0;
    if_c.in_valid = 1'b0; if_c.in_mode = 2'b00; if_c.in_num = '0;

    // 1: reset, one-hot, hold
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_res", 32'(if_a.res), 32'h0);
    chk("rst_valid", 32'(if_a.res_valid), 32'h0);
    chk("rst_busy", 32'(if_a.busy), 32'h0);
    chk("rst_done", 32'(if_a.scan_done), 32'h0);
    chk("rst_ready", 32'(if_a.in_ready), 32'h1);

    if_a.in_valid = 1'b1; if_a.in_mode = 2'b00; if_a.in_num = 3'd7;
    tick();
    if_a.in_valid = 1'b0;
    chk("oh7_res", 32'(if_a.res), 32'h80);
    chk("oh7_valid", 32'(if_a.res_valid), 32'h1);
    repeat (300) tick();
    chk("oh7_hold", 32'(if_a.res), 32'h80);

    if_a.in_valid = 1'b1; if_a.in_mode = 2'b00; if_a.in_num = 3'd2;
    tick();
    if_a.in_valid = 1'b0;
    chk("oh2_res", 32'(if_a.res), 32'h04);

    // 2: thermometer
    if_a.in_valid = 1'b1; if_a.in_mode = 2'b01; if_a.in_num = 3'd0;
    tick();
    chk("th0_res", 32'(if_a.res), 32'h01);
    chk("th0_ready", 32'(if_a.in_ready), 32'h1);
    if_a.in_num = 3'd3;
    tick();
    chk("th3_res", 32'(if_a.res), 32'h0F);
    chk("th3_ready", 32'(if_a.in_ready), 32'h1);
    if_a.in_num = 3'd7;
    tick();
    if_a.in_valid = 1'b0;
    chk("th7_res", 32'(if_a.res), 32'hFF);
    chk("th7_ready", 32'(if_a.in_ready), 32'h1);
    chk("th7_valid", 32'(if_a.res_valid), 32'h1);

    // 3: scan num=3, DWELL=4, with an ignored mid-scan command
    if_a.in_valid = 1'b1; if_a.in_mode = 2'b10; if_a.in_num = 3'd3;
    tick();
    if_a.in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 5) begin
        if_a.in_valid = 1'b1; if_a.in_mode = 2'b00; if_a.in_num = 3'd6;
      end
      if (k == 6) if_a.in_valid = 1'b0;
      chk($sformatf("scan3_res_%0d", k), 32'(if_a.res),
          32'(8'h01 << (k / 4)));
      chk($sformatf("scan3_busy_%0d", k), 32'(if_a.busy), 32'h1);
      chk($sformatf("scan3_ready_%0d", k), 32'(if_a.in_ready), 32'h0);
      chk($sformatf("scan3_done_%0d", k), 32'(if_a.scan_done), 32'h0);
      chk($sformatf("scan3_valid_%0d", k), 32'(if_a.res_valid), 32'h1);
      tick();
    end
    chk("scan3_end_res", 32'(if_a.res), 32'h0);
    chk("scan3_end_valid", 32'(if_a.res_valid), 32'h0);
    chk("scan3_end_done", 32'(if_a.scan_done), 32'h1);
    chk("scan3_end_ready", 32'(if_a.in_ready), 32'h1);
    chk("scan3_end_busy", 32'(if_a.busy), 32'h0);
    tick();
    chk("scan3_done_pulse", 32'(if_a.scan_done), 32'h0);
    chk("scan3_after_res", 32'(if_a.res), 32'h0);

    // 4: scan num=0, DWELL=1, command in the done cycle
    if_b.in_valid = 1'b1; if_b.in_mode = 2'b10; if_b.in_num = 3'd0;
    tick();
    if_b.in_valid = 1'b0;
    chk("scan0_res", 32'(if_b.res), 32'h01);
    chk("scan0_busy", 32'(if_b.busy), 32'h1);
    tick();
    chk("scan0_done", 32'(if_b.scan_done), 32'h1);
    chk("scan0_end_res", 32'(if_b.res), 32'h0);
    chk("scan0_ready", 32'(if_b.in_ready), 32'h1);
    if_b.in_valid = 1'b1; if_b.in_mode = 2'b00; if_b.in_num = 3'd5;
    tick();
    if_b.in_valid = 1'b0;
    chk("scan0_oh5_res", 32'(if_b.res), 32'h20);
    chk("scan0_oh5_valid", 32'(if_b.res_valid), 32'h1);
    chk("scan0_done_clr", 32'(if_b.scan_done), 32'h0);

    // 5: async reset mid-scan at position 4
    if_a.in_valid = 1'b1; if_a.in_mode = 2'b10; if_a.in_num = 3'd7;
    tick();
    if_a.in_valid = 1'b0;
    repeat (17) tick();
    chk("scan7_pos4", 32'(if_a.res), 32'h10);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_res", 32'(if_a.res), 32'h0);
    chk("arst_busy", 32'(if_a.busy), 32'h0);
    chk("arst_ready", 32'(if_a.in_ready), 32'h1);
    chk("arst_valid", 32'(if_a.res_valid), 32'h0);
    tick();
    chk("arst_done", 32'(if_a.scan_done), 32'h0);
    rst = 1'b0;
    tick();
    chk("arst_done2", 32'(if_a.scan_done), 32'h0);
    chk("arst_res2", 32'(if_a.res), 32'h0);

    // 6: IN_W=4 thermometer and clear
    if_c.in_valid = 1'b1; if_c.in_mode = 2'b01; if_c.in_num = 4'd15;
    tick();
    chk("w4_th15_res", 32'(if_c.res), 32'hFFFF);
    chk("w4_th15_valid", 32'(if_c.res_valid), 32'h1);
    if_c.in_mode = 2'b00; if_c.in_num = 4'd9;
    tick();
    chk("w4_oh9_res", 32'(if_c.res), 32'h0200);
    if_c.in_mode = 2'b11;
    tick();
    if_c.in_valid = 1'b0;
    chk("w4_clr_res", 32'(if_c.res), 32'h0);
    chk("w4_clr_valid", 32'(if_c.res_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
